// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared CPU register-bank widths and writeback arbitration types
package wb_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_FIFO} wb_sel_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipeline, issue, multi-cycle result and register-bank write signals of the writeback arbiter
interface wb_arbiter_if #(
  parameter int DATA_W = wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = wb_arbiter_pkg::ADDR_W
);
  logic pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic mc_valid;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;
  logic mc_ready;
  logic we;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic [(1<<ADDR_W)-1:0] pending;
  logic hazard_err;
  modport master (
    output pipe_we, pipe_addr, pipe_data, issue_valid, issue_addr, mc_valid, mc_addr, mc_data,
    input mc_ready, we, addr_d, data_d, pending, hazard_err
  );
  modport slave (
    input pipe_we, pipe_addr, pipe_data, issue_valid, issue_addr, mc_valid, mc_addr, mc_data,
    output mc_ready, we, addr_d, data_d, pending, hazard_err
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous power-of-two FIFO with registered occupancy count
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 36
) (
  input logic clk,
  input logic reset,
  input logic i_push,
  input logic [W-1:0] i_data,
  input logic i_pop,
  output logic [W-1:0] o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push && r_count < (PW+1)'(DEPTH);
  assign w_pop = i_pop && |r_count;
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter giving the single-cycle pipe priority over buffered
// multi-cycle results, with a pending-register scoreboard and sticky hazard flag
module wb_arbiter #(
  parameter int DATA_W = wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W = wb_arbiter_pkg::ADDR_W,
  parameter int FIFO_DEPTH = wb_arbiter_pkg::FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  wb_arbiter_if.slave bus
);
  import wb_arbiter_pkg::*;
  localparam int NR = 1 << ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] w_count;
  logic [ADDR_W+DATA_W-1:0] w_head;
  logic [ADDR_W-1:0] w_head_addr;
  logic w_pipe, w_pop, w_push, w_haz;
  logic [NR-1:0] w_set, w_clr;
  wb_sel_e w_sel;
  logic r_we, r_haz;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NR-1:0] r_pending;
  assign w_head_addr = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign bus.mc_ready = w_count < CW'(FIFO_DEPTH);
  assign w_push = bus.mc_valid && bus.mc_ready;
  assign w_pipe = bus.pipe_we && |bus.pipe_addr;
  // a zero-address pipe write yields the slot, so the FIFO head may still drain
  assign w_pop = !w_pipe && |w_count;
  always_comb w_sel = w_pipe ? SEL_PIPE : (w_pop && |w_head_addr) ? SEL_FIFO : SEL_NONE;
  assign w_set = (bus.issue_valid && |bus.issue_addr) ? NR'(1) << bus.issue_addr : '0;
  assign w_clr = (w_sel == SEL_FIFO) ? NR'(1) << w_head_addr : '0;
  assign w_haz = (bus.issue_valid && r_pending[bus.issue_addr]) ||
                 (w_pipe && r_pending[bus.pipe_addr]) ||
                 (w_push && !r_pending[bus.mc_addr]);
  wb_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W+DATA_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_data({bus.mc_addr, bus.mc_data}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_count(w_count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_pending <= '0;
      r_haz <= 1'b0;
    end else begin
      r_we <= w_sel != SEL_NONE;
      if (w_sel == SEL_PIPE) begin
        r_addr <= bus.pipe_addr;
        r_data <= bus.pipe_data;
      end else if (w_sel == SEL_FIFO) begin
        r_addr <= w_head_addr;
        r_data <= w_head[DATA_W-1:0];
      end
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_haz <= r_haz | w_haz;
    end
  end
  assign bus.we = r_we;
  assign bus.addr_d = r_addr;
  assign bus.data_d = r_data;
  assign bus.pending = r_pending;
  assign bus.hazard_err = r_haz;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-003 Parameter FIFO_DEPTH, default 2, multi-cycle result buffer entries, power of two, at least 2.
REQ-004 clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 pipe_we  in  1  single-cycle pipeline result valid this cycle.
REQ-006 pipe_addr  in  ADDR_W  destination register of the pipeline result.
REQ-007 pipe_data  in  DATA_W  pipeline result value.
REQ-008 issue_valid  in  1  multi-cycle op issued this cycle.
REQ-009 issue_addr  in  ADDR_W  destination register of the issued op.
REQ-010 mc_valid  in  1  multi-cycle result offered.
REQ-011 mc_addr  in  ADDR_W  destination register of the multi-cycle result.
REQ-012 mc_data  in  DATA_W  multi-cycle result value.
REQ-013 mc_ready  out  1  buffer can accept the multi-cycle result.
REQ-014 we  out  1  register bank write enable.
REQ-015 addr_d  out  ADDR_W  register bank write address.
REQ-016 data_d  out  DATA_W  register bank write data.
REQ-017 pending  out  2^ADDR_W  scoreboard, bit n set = register n awaits a multi-cycle result.
REQ-018 hazard_err  out  1  sticky ordering-violation flag.

Function
REQ-019 A multi-cycle result is accepted when mc_valid and mc_ready are both high on a rising edge; it is then pushed into the FIFO.
REQ-020 mc_ready is high exactly when the registered FIFO count is below FIFO_DEPTH; it does not depend on mc_valid or on a same-cycle pop.
REQ-021 Arbitration each cycle: pipe_we with pipe_addr nonzero wins; otherwise, if the FIFO is non-empty at cycle start, the head is popped.
REQ-022 The selected write is presented on we/addr_d/data_d as registered outputs one cycle later; if nothing is selected, we is 0 and addr_d/data_d hold their previous values.
REQ-023 pipe_we with pipe_addr 0 consumes no slot and produces no write; the FIFO may pop that cycle.
REQ-024 A FIFO entry with address 0 is popped and discarded: it produces we 0 and changes no pending bit.
REQ-025 An entry pushed in cycle N is first eligible for pop in cycle N+1, so the minimum latency from acceptance to we is 2 cycles.
REQ-026 Simultaneous push and pop leave the count unchanged; FIFO pointers wrap modulo FIFO_DEPTH; entries pop in acceptance order.
REQ-027 issue_valid with issue_addr nonzero sets pending[issue_addr] on the next edge.
REQ-028 Popping an entry with a nonzero address clears pending[addr] on the same edge that registers its write.
REQ-029 If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-030 pending[0] is always 0.
REQ-031 hazard_err is set, and stays set until reset, on any of: issue_valid to a register already pending; pipe_we (nonzero address) to a pending register; acceptance of a result whose register is not pending.
REQ-032 A hazard does not block or alter any write, push, pop or pending update.

Reset
REQ-033 On reset: we 0, addr_d 0, data_d 0, pending all 0, hazard_err 0, FIFO count and pointers 0; mc_ready is 1 in the cycle after reset.
REQ-034 Reset mid-operation discards all buffered entries and any write not yet presented; inputs sampled during reset are ignored.

Structure
REQ-035 ADDR_W, DATA_W and the register-count constant 2^ADDR_W belong in the shared CPU package, alongside the register bank's definitions.
REQ-036 The buffer is one sub-module, wb_fifo (synchronous, depth-parameterized, count output); the arbiter, output register and scoreboard live in wb_arbiter.

Verification
REQ-037 issue r5; 3 cycles later mc r5=0xDEADBEEF, no pipe traffic -> we=1, addr_d=5, data_d=0xDEADBEEF 2 cycles after acceptance; pending[5] clears on that same edge.
REQ-038 Buffered mc r3=0x11 while pipe_we r7=0x22 in every cycle for 4 cycles -> 4 writes to r7 first; r3 is written in the first cycle pipe_we drops; hazard_err stays 0.
REQ-039 Issue r1, r2 and r4; hold pipe_we high with a nonzero address; offer 3 mc results back to back -> mc_ready goes 0 after 2 accepts; dropping pipe_we drains r1, r2, r4 in order with no loss.
REQ-040 pipe_we r0=0x55 with one buffered entry r6=0x66 -> r0 produces no write; r6 is written the next cycle.
REQ-041 issue r9 while pending[9]=1 -> hazard_err=1 and stays 1 until reset; reset with 2 buffered entries -> we stays 0, pending=0, mc_ready=1.
REQ-042 issue r8 and pop of r8 in the same cycle -> pending[8] remains 1 after the edge.
